// File: rtl/cpu_pkg.sv
// Shared constants and enums for the 16-bit five-stage CPU pipeline.
package cpu_pkg;

  localparam int DW = 16;
  localparam int RW = 4;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_MEM  = 2'b01,
    WB_LINK = 2'b10,
    WB_RSVD = 2'b11
  } wb_sel_t;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    HALTING = 2'b01,
    HALTED  = 2'b10
  } halt_state_t;

endpackage

// File: rtl/mem_wb_stage_pipe_reg.sv
// Generic pipeline field register: async reset, load enable, synchronous clear.
// A clear overrides the enable so a bubble can be forced into a stalled slot.
module pipe_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (en) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/mem_wb_stage.sv
// M/W pipeline register with writeback select, sticky halt FSM and retire counter.
// Optional feature: define MWB_RETIRE_CNT_EN to build the 32-bit retire counter.
module mem_wb_stage
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          xm_valid,
  input  logic [DW-1:0] xm_instruction,
  input  logic          xm_reg_write,
  input  logic [RW-1:0] xm_reg_dest,
  input  logic [1:0]    xm_wb_sel,
  input  logic [DW-1:0] xm_alu_result,
  input  logic [DW-1:0] xm_pc_plus2,
  input  logic          xm_halt,
  input  logic [DW-1:0] mem_rdata,
  input  logic          stall,
  input  logic          flush,
  output logic [DW-1:0] mw_instruction,
  output logic          mw_reg_write,
  output logic [RW-1:0] mw_reg_dest,
  output logic [DW-1:0] writeback_data,
  output logic          fwd_valid,
  output logic          hlt,
  output logic [31:0]   retire_count
);

  halt_state_t   state_q, state_d;
  logic          hlt_q;
  logic          slot_clr;
  logic          capture_ok;
  logic [DW-1:0] wb_data_d;
  logic [DW-1:0] wb_data_q;
  logic          mw_valid;
  logic          mw_rw_raw;

  // Once halted, every later capture is replaced by a bubble.
  assign slot_clr   = hlt_q | flush;
  assign capture_ok = xm_valid & ~flush & ~stall & ~hlt_q;

  always_comb begin
    wb_data_d = xm_alu_result;
    case (wb_sel_t'(xm_wb_sel))
      WB_MEM:  wb_data_d = mem_rdata;
      WB_LINK: wb_data_d = xm_pc_plus2;
      default: wb_data_d = xm_alu_result;
    endcase
  end

  pipe_reg #(.W(2 + RW)) u_ctrl_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (~stall),
    .clr   (slot_clr),
    .d     ({xm_valid, xm_reg_write, xm_reg_dest}),
    .q     ({mw_valid, mw_rw_raw, mw_reg_dest})
  );

  pipe_reg #(.W(DW)) u_instr_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (~stall),
    .clr   (slot_clr),
    .d     (xm_instruction),
    .q     (mw_instruction)
  );

  pipe_reg #(.W(DW)) u_data_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (~stall),
    .clr   (slot_clr),
    .d     (wb_data_d),
    .q     (wb_data_q)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (capture_ok && xm_halt) state_d = HALTING;
      HALTING: state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      hlt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hlt_q   <= (state_d != RUN);
    end
  end

  assign hlt            = hlt_q;
  assign writeback_data = wb_data_q;
  assign mw_reg_write   = mw_valid & mw_rw_raw & (mw_reg_dest != '0) & ~hlt_q;
  assign fwd_valid      = mw_reg_write;

`ifdef MWB_RETIRE_CNT_EN
  logic [31:0] retire_q, retire_d;

  always_comb begin
    retire_d = retire_q + (capture_ok ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_q <= 32'h0;
    end else begin
      retire_q <= retire_d;
    end
  end

  assign retire_count = retire_q;
`else
  assign retire_count = 32'h0;
`endif

endmodule
